// File: rtl/riscv_id_pkg.sv
// Shared RV32 decode constants and types for the ID/add datapath.
package riscv_id_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  // Contents of the EX/WB stage register
  typedef struct packed {
    word_t     result;
    logic      zero;
    reg_addr_t rd;
  } ex_stage_t;

endpackage

// File: rtl/imm_sext.sv
// Sign-extends a 12-bit I-type immediate to a 32-bit word.
import riscv_id_pkg::*;

module imm_sext (
  input  logic [11:0] imm,
  output word_t       imm_ex
);

  assign imm_ex = {{20{imm[11]}}, imm};

endmodule

// File: rtl/id_add_datapath.sv
// RV32 decode + add datapath with a single EX/WB register stage.
// Optional feature macro: ALU_SUB_EN -- R-type funct3=000/funct7=0100000
// computes doa - dob instead of doa + dob.
import riscv_id_pkg::*;

module id_add_datapath #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  word_t           instr_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] doa_i,
  input  logic [XLEN-1:0] dob_i,
  output logic [6:0]      opcode_o,
  output reg_addr_t       rd_o,
  output logic [2:0]      funct3_o,
  output reg_addr_t       rs1_o,
  output reg_addr_t       rs2_o,
  output logic [6:0]      funct7_o,
  output logic [11:0]     imm_o,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic [XLEN-1:0] ex_result_q,
  output logic            ex_zero_q,
  output reg_addr_t       ex_rd_q,
  output logic            ex_valid_q
);

  logic [XLEN-1:0] imm_ex;
  logic [XLEN-1:0] op_b;
  ex_stage_t       ex_q;

  // Field slices are raw: not qualified by valid_i
  assign opcode_o = instr_i[6:0];
  assign rd_o     = instr_i[11:7];
  assign funct3_o = instr_i[14:12];
  assign rs1_o    = instr_i[19:15];
  assign rs2_o    = instr_i[24:20];
  assign funct7_o = instr_i[31:25];
  assign imm_o    = instr_i[31:20];

  imm_sext u_imm_sext (
    .imm    (imm_o),
    .imm_ex (imm_ex)
  );

  // Bit 5 of the opcode separates OP (register) from OP_IMM (immediate)
  assign op_b = instr_i[5] ? dob_i : imm_ex;

`ifdef ALU_SUB_EN
  logic is_sub;
  assign is_sub = instr_i[5] && (funct3_o == 3'b000) && (funct7_o == F7_SUB);

  // Add, or subtract for R-type SUB; wraps modulo 2^XLEN
  always_comb begin
    result_o = doa_i + op_b;
    if (is_sub) result_o = doa_i - dob_i;
  end
`else
  // Every instruction adds; carry out is dropped
  always_comb begin
    result_o = doa_i + op_b;
  end
`endif

  assign zero_o = (result_o == '0);

  // EX/WB stage: data captures every cycle, consumers qualify with ex_valid_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q.result <= result_o;
      ex_q.zero   <= zero_o;
      ex_q.rd     <= rd_o;
      ex_valid_q  <= valid_i;
    end
  end

  assign ex_result_q = ex_q.result;
  assign ex_zero_q   = ex_q.zero;
  assign ex_rd_q     = ex_q.rd;

endmodule

// File: tb/tb_id_add_datapath.sv
// Randomized scoreboard bench for id_add_datapath.
module tb_id_add_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_i;
  logic        valid_i;
  logic [31:0] doa_i, dob_i;
  logic [6:0]  opcode_o, funct7_o;
  logic [4:0]  rd_o, rs1_o, rs2_o, ex_rd_q;
  logic [2:0]  funct3_o;
  logic [11:0] imm_o;
  logic [31:0] result_o, ex_result_q;
  logic        zero_o, ex_zero_q, ex_valid_q;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic [4:0]  rd;
    logic        valid;
  } exp_t;

  exp_t sb[$];

  id_add_datapath #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .instr_i(instr_i), .valid_i(valid_i),
    .doa_i(doa_i), .dob_i(dob_i), .opcode_o(opcode_o), .rd_o(rd_o),
    .funct3_o(funct3_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .funct7_o(funct7_o),
    .imm_o(imm_o), .result_o(result_o), .zero_o(zero_o),
    .ex_result_q(ex_result_q), .ex_zero_q(ex_zero_q), .ex_rd_q(ex_rd_q),
    .ex_valid_q(ex_valid_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: operand B is rs2 data for R-type, signed immediate for I-type
  function automatic logic [31:0] model(input logic [31:0] ins, input logic [31:0] a,
                                        input logic [31:0] b);
    longint opb;
    longint sum;
    if (ins[5]) opb = longint'(b);
    else opb = ins[31] ? longint'(ins[31:20]) - 4096 : longint'(ins[31:20]);
`ifdef ALU_SUB_EN
    if (ins[5] && ins[14:12] == 3'd0 && ins[31:25] == 7'd32)
      opb = -longint'(b);
`endif
    sum = longint'(a) + opb;
    return sum[31:0];
  endfunction

  // Drive one cycle at negedge, check combinational outputs, push expectation
  task automatic drive(input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic v);
    exp_t e;
    @(negedge clk);
    instr_i = ins; doa_i = a; dob_i = b; valid_i = v;
    #1;
    e.result = model(ins, a, b);
    e.zero   = (e.result == 0);
    e.rd     = ins[11:7];
    e.valid  = v;
    chk("result_o", result_o, e.result);
    chk("zero_o", {31'd0, zero_o}, {31'd0, e.zero});
    sb.push_back(e);
  endtask

  // Monitor: every capture edge out of reset consumes one expectation
  always @(posedge clk) begin
    #1;
    if (!rst && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ex_valid_q", {31'd0, ex_valid_q}, {31'd0, e.valid});
      chk("ex_result_q", ex_result_q, e.result);
      chk("ex_zero_q", {31'd0, ex_zero_q}, {31'd0, e.zero});
      chk("ex_rd_q", {27'd0, ex_rd_q}, {27'd0, e.rd});
    end
  end

  initial begin
    logic [31:0] ins, a, b;
    rst = 1'b1; instr_i = '0; valid_i = 1'b0; doa_i = '0; dob_i = '0;
    #2;
    chk("reset ex_result_q", ex_result_q, 32'd0);
    chk("reset ex_valid_q", {31'd0, ex_valid_q}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // ADDI x6,x28,3
    drive(32'h003E0313, 32'd10, 32'd0, 1'b1);
    chk("addi rs1", {27'd0, rs1_o}, 32'd28);
    chk("addi rd", {27'd0, rd_o}, 32'd6);
    chk("addi imm", {20'd0, imm_o}, 32'd3);
    chk("addi result", result_o, 32'd13);
    // I-type imm = -1, doa = 1 -> zero
    drive(32'hFFF00013, 32'd1, 32'h1234, 1'b1);
    chk("imm fff result", result_o, 32'd0);
    chk("imm fff zero", {31'd0, zero_o}, 32'd1);
    // ADD x6,x28,x6
    drive(32'h006E0333, 32'd5, 32'd7, 1'b1);
    chk("add result", result_o, 32'd12);
    chk("add opcode", {25'd0, opcode_o}, 32'h33);
    // R-type wrap-around
    drive(32'h006E0333, 32'hFFFFFFFF, 32'd1, 1'b1);
    chk("wrap result", result_o, 32'd0);
    chk("wrap zero", {31'd0, zero_o}, 32'd1);
    // SUB x6,x28,x6 with equal operands
    drive(32'h406E0333, 32'd9, 32'd9, 1'b1);
`ifdef ALU_SUB_EN
    chk("sub result", result_o, 32'd0);
`else
    chk("sub-as-add result", result_o, 32'd18);
`endif
    // Invalid slot still captures data
    drive(32'h00500093, 32'd1, 32'd0, 1'b0);

    // Random traffic, with a bias toward SUB encodings and zero results
    for (int i = 0; i < 300; i++) begin
      ins = $urandom;
      ins[6:0] = ($urandom_range(0, 1) == 1) ? 7'b0110011 : 7'b0010011;
      if ($urandom_range(0, 3) == 0) begin ins[31:25] = 7'b0100000; ins[14:12] = 3'b000; end
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) a = model(ins, 32'd0, b) * 32'hFFFFFFFF;
      drive(ins, a, b, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset between edges
    drive(32'h003E0313, 32'd10, 32'd0, 1'b1);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("async rst ex_result_q", ex_result_q, 32'd0);
    chk("async rst ex_valid_q", {31'd0, ex_valid_q}, 32'd0);
    chk("async rst ex_rd_q", {27'd0, ex_rd_q}, 32'd0);
    chk("comb during rst", result_o, 32'd13);
    @(posedge clk); #1;
    chk("held rst ex_result_q", ex_result_q, 32'd0);
    @(negedge clk) rst = 1'b0;
    drive(32'h006E0333, 32'd20, 32'd22, 1'b1);
    drive(32'h00000013, 32'd0, 32'd0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
